instruction_fetch: RTL and testbench

- IF stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and drives the instruction-memory address.
- Presents the fetched word and PC+4 to IF/ID, which consumes them as its instruction and next-instruction inputs.
- Handles stall, branch/jump redirect, wrong-path squash, halt detection and a retired-fetch counter.

---
 rtl/mips_pkg.sv | 16 +
 rtl/pc_reg.sv | 33 +++
 rtl/instruction_fetch.sv | 84 ++++++++
 tb/tb_instruction_fetch.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Types and constants shared by the MIPS instruction-fetch stage.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } if_state_e;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: synchronous active-low reset, enable, and a load
// that selects an external target instead of the sequential increment.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] load_pc,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = load ? load_pc : (pc_q + PC_INC);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (en) begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, presents the fetched word and PC+4 to IF/ID, and
// handles stall, redirect squash, halt detection and a retired-fetch counter.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
    parameter logic [31:0] HALT_WORD = mips_pkg::HALT_WORD,
    parameter logic [31:0] NOP_WORD  = mips_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    if_state_e   state_q;
    logic [31:0] fetch_count_q;
    logic [31:0] pc;
    logic        active;
    logic        is_halt_word;
    logic        pc_en;
    logic        pc_load;

    assign active       = (state_q == RUN) || (state_q == STALL);
    assign is_halt_word = (imem_rdata == HALT_WORD);

    // Redirect wins over stall and halt; otherwise the PC only moves on an
    // unstalled, non-halt word.
    assign pc_load = active && redirect;
    assign pc_en   = active && (redirect || (!stall && !is_halt_word));

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pc_en),
        .load    (pc_load),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            fetch_count_q <= 32'd0;
        end else begin
            case (state_q)
                BOOT: state_q <= RUN;
                RUN, STALL: begin
                    if (redirect) begin
                        state_q <= RUN;
                    end else if (stall) begin
                        state_q <= STALL;
                    end else if (is_halt_word) begin
                        state_q <= HALT;
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= HALT;
            endcase
            if (fetch_valid && !stall) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
        end
    end

    assign fetch_valid = active && !redirect && !is_halt_word;
    assign instruction = fetch_valid ? imem_rdata : NOP_WORD;
    assign imem_addr   = pc;
    assign pc_plus4    = pc + PC_INC;
    assign halted      = (state_q == HALT);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: each vector pushes its expected
// outputs into a scoreboard queue, and a negedge monitor pops and compares.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic [31:0] fetch_count;
    logic        halt_en;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic        valid;
        logic        halted;
        logic [31:0] count;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   n_push = 0;

    instruction_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc_plus4    (pc_plus4),
        .fetch_valid (fetch_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ordinary words are 0x2400_0000 | addr; optional halt word at 0x8.
    assign imem_rdata = (halt_en && imem_addr == 32'h8) ? 32'hFFFF_FFFF
                                                        : (32'h2400_0000 | imem_addr);

    task automatic step(input logic r, input logic s, input logic rd,
                        input logic [31:0] rpc, input logic [31:0] e_addr,
                        input logic e_valid, input logic e_halted,
                        input logic [31:0] e_count);
        exp_t e;
        rst_n       = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        e.id     = n_push;
        e.addr   = e_addr;
        e.valid  = e_valid;
        e.halted = e_halted;
        e.count  = e_count;
        e.instr  = e_valid ? (32'h2400_0000 | e_addr) : 32'h0000_0000;
        sb.push_back(e);
        n_push++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            int   bad;
            e = sb.pop_front();
            bad = 0;
            n_vec++;
            if (imem_addr !== e.addr) begin
                $display("FAIL vec%0d imem_addr got=%h exp=%h", e.id, imem_addr, e.addr); bad++;
            end
            if (pc_plus4 !== e.addr + 32'd4) begin
                $display("FAIL vec%0d pc_plus4 got=%h exp=%h", e.id, pc_plus4, e.addr + 32'd4); bad++;
            end
            if (fetch_valid !== e.valid) begin
                $display("FAIL vec%0d fetch_valid got=%b exp=%b", e.id, fetch_valid, e.valid); bad++;
            end
            if (instruction !== e.instr) begin
                $display("FAIL vec%0d instruction got=%h exp=%h", e.id, instruction, e.instr); bad++;
            end
            if (halted !== e.halted) begin
                $display("FAIL vec%0d halted got=%b exp=%b", e.id, halted, e.halted); bad++;
            end
            if (fetch_count !== e.count) begin
                $display("FAIL vec%0d fetch_count got=%0d exp=%0d", e.id, fetch_count, e.count); bad++;
            end
            n_miss += bad;
            if (bad == 0)
                $display("vec%0d ok addr=%h valid=%b halted=%b count=%0d",
                         e.id, imem_addr, fetch_valid, halted, fetch_count);
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        //    rst s  rd rpc            addr           v  h  count
        step(0, 0, 0, 32'h0,         32'h0000_0000, 0, 0, 0);   // held in reset
        step(1, 0, 0, 32'h0,         32'h0000_0000, 0, 0, 0);   // BOOT
        step(1, 0, 0, 32'h0,         32'h0000_0000, 1, 0, 0);
        step(1, 0, 0, 32'h0,         32'h0000_0004, 1, 0, 1);
        step(1, 0, 0, 32'h0,         32'h0000_0008, 1, 0, 2);
        step(1, 0, 0, 32'h0,         32'h0000_000C, 1, 0, 3);
        step(1, 1, 0, 32'h0,         32'h0000_0010, 1, 0, 4);   // stall x3
        step(1, 1, 0, 32'h0,         32'h0000_0010, 1, 0, 4);
        step(1, 1, 0, 32'h0,         32'h0000_0010, 1, 0, 4);
        step(1, 0, 0, 32'h0,         32'h0000_0010, 1, 0, 4);   // release
        step(1, 0, 0, 32'h0,         32'h0000_0014, 1, 0, 5);
        step(1, 0, 0, 32'h0,         32'h0000_0018, 1, 0, 6);
        step(1, 0, 0, 32'h0,         32'h0000_001C, 1, 0, 7);
        step(1, 1, 1, 32'h40,        32'h0000_0020, 0, 0, 8);   // redirect + stall
        step(1, 0, 0, 32'h0,         32'h0000_0040, 1, 0, 8);
        step(1, 0, 1, 32'hFFFF_FFFC, 32'h0000_0044, 0, 0, 9);   // redirect to top
        step(1, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 0, 9);   // pc_plus4 wraps
        step(1, 0, 0, 32'h0,         32'h0000_0000, 1, 0, 10);
        halt_en = 1'b1;
        step(1, 0, 0, 32'h0,         32'h0000_0004, 1, 0, 11);
        step(1, 0, 0, 32'h0,         32'h0000_0008, 0, 0, 12);  // halt word
        step(1, 0, 1, 32'h100,       32'h0000_0008, 0, 1, 12);  // redirect ignored
        step(1, 1, 0, 32'h0,         32'h0000_0008, 0, 1, 12);  // stall ignored
        step(0, 0, 0, 32'h0,         32'h0000_0008, 0, 1, 12);  // reset while halted
        step(1, 0, 0, 32'h0,         32'h0000_0000, 0, 0, 0);   // BOOT again
        step(1, 0, 0, 32'h0,         32'h0000_0000, 1, 0, 0);
        step(1, 0, 0, 32'h0,         32'h0000_0004, 1, 0, 1);
        step(1, 1, 0, 32'h0,         32'h0000_0008, 0, 0, 2);   // stall beats halt
        step(1, 0, 0, 32'h0,         32'h0000_0008, 0, 0, 2);   // STALL -> HALT
        step(1, 0, 0, 32'h0,         32'h0000_0008, 0, 1, 2);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
            n_miss++;
        end
        if (n_vec != n_push) begin
            $display("FAIL vector_count got=%0d required=%0d", n_vec, n_push);
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
